// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - configurable serial pattern detector with match counting (option: SEQ_DET_OVERLAP_EN)
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic [CNT_W-1:0]   cfg_target,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               data,
    input  logic               data_valid,
    output logic               busy,
    output logic               hit,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               done
);

    localparam int FW = $clog2(MAX_LEN + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(MAX_LEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [MAX_LEN-1:0] pat_q;
    logic [3:0]         len_q;
    logic [CNT_W-1:0]   target_q;
    logic               cfg_loaded;
    logic               err_q;

    logic [MAX_LEN-1:0] sr;
    logic [FW-1:0]      fill;
    logic [CNT_W-1:0]   cnt;
    logic               hit_q;

    logic               cfg_fire;
    logic               cfg_len_ok;
    logic [MAX_LEN-1:0] shifted;
    logic [MAX_LEN-1:0] mask;
    logic [FW-1:0]      fill_inc;
    logic               fill_ok;
    logic               window_eq;
    logic               shift_en;
    logic               match;
    logic [CNT_W-1:0]   cnt_inc;
    logic               reach;
    logic               start_run;

    // Handshake, shift/compare window and match qualification
    always_comb begin
        cfg_fire   = cfg_valid && (state == S_IDLE);
        cfg_len_ok = (cfg_len != 4'd0) && (int'(cfg_len) <= MAX_LEN);
        shifted    = {sr[MAX_LEN-2:0], data};
        fill_inc   = (fill == FILL_MAX) ? fill : fill + 1'b1;
        fill_ok    = int'(fill_inc) >= int'(len_q);
        mask       = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        window_eq  = ((shifted ^ pat_q) & mask) == '0;
        // abort pre-empts any bit sampled in the same cycle
        shift_en   = (state == S_RUN) && data_valid && !abort;
        match      = shift_en && fill_ok && window_eq;
        cnt_inc    = (&cnt) ? cnt : cnt + 1'b1;
        reach      = match && (target_q != '0) && (cnt_inc == target_q);
        start_run  = start && (((state == S_IDLE) && cfg_loaded) ||
                               ((state == S_DONE) && !abort));
    end

    // Run-control state machine; abort has priority over start and target reach
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start && cfg_loaded) state <= S_RUN;
                S_RUN: begin
                    if (abort)      state <= S_IDLE;
                    else if (reach) state <= S_DONE;
                end
                S_DONE: begin
                    if (abort)      state <= S_IDLE;
                    else if (start) state <= S_RUN;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Configuration capture; an illegal length completes the handshake but only flags an error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q      <= '0;
            len_q      <= '0;
            target_q   <= '0;
            cfg_loaded <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (cfg_fire) begin
                if (cfg_len_ok) begin
                    pat_q      <= cfg_pattern;
                    len_q      <= cfg_len;
                    target_q   <= cfg_target;
                    cfg_loaded <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Shift register, fill count, match counter and hit pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr    <= '0;
            fill  <= '0;
            cnt   <= '0;
            hit_q <= 1'b0;
        end else if (start_run) begin
            sr    <= '0;
            fill  <= '0;
            cnt   <= '0;
            hit_q <= 1'b0;
        end else if (shift_en) begin
            sr    <= shifted;
            hit_q <= match;
`ifdef SEQ_DET_OVERLAP_EN
            fill  <= fill_inc;
`else
            // a match consumes its bits; the next match needs a fresh window
            fill  <= match ? '0 : fill_inc;
`endif
            if (match) cnt <= cnt_inc;
        end else begin
            hit_q <= 1'b0;
        end
    end

    assign cfg_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign hit       = hit_q;
    assign match_cnt = cnt;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - directed self-checking bench for seq_det_ctrl
module tb_seq_det_ctrl;

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OV = 1'b1;
`else
    localparam bit OV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_target;
    logic       cfg_err;
    logic       start;
    logic       abort;
    logic       data;
    logic       data_valid;
    logic       busy;
    logic       hit;
    logic [7:0] match_cnt;
    logic       done;

    int checks = 0;
    int errors = 0;

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_target(cfg_target), .cfg_err(cfg_err),
        .start(start), .abort(abort), .data(data), .data_valid(data_valid),
        .busy(busy), .hit(hit), .match_cnt(match_cnt), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] tgt);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_target  = tgt;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic send_bit(input string tag, input logic b, input logic exp_hit,
                            input logic [7:0] exp_cnt, input logic exp_done);
        data       = b;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check({tag, "_hit"}, hit, exp_hit);
        check({tag, "_cnt"}, match_cnt, exp_cnt);
        check({tag, "_done"}, done, exp_done);
    endtask

    initial begin
        logic [7:0] bits8;
        rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
        start = 1'b0; abort = 1'b0; data = 1'b0; data_valid = 1'b0;

        // reset values before any clock edge
        #2;
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hit", hit, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_cnt", match_cnt, 8'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // start without configuration is ignored
        pulse_start();
        check("nocfg_start_busy", busy, 1'b0);

        // illegal length 0
        do_cfg(8'h12, 4'd0, 8'd0);
        check("len0_err", cfg_err, 1'b1);
        tick();
        check("len0_err_pulse", cfg_err, 1'b0);
        pulse_start();
        check("len0_start_busy", busy, 1'b0);

        // overlapping-pattern stream 10010010, pattern 10010
        do_cfg(8'b0001_0010, 4'd5, 8'd0);
        check("p5_cfg_err", cfg_err, 1'b0);
        pulse_start();
        check("p5_busy", busy, 1'b1);
        check("p5_cnt0", match_cnt, 8'd0);
        send_bit("p5_b1", 1'b1, 1'b0, 8'd0, 1'b0);
        send_bit("p5_b2", 1'b0, 1'b0, 8'd0, 1'b0);
        send_bit("p5_b3", 1'b0, 1'b0, 8'd0, 1'b0);
        send_bit("p5_b4", 1'b1, 1'b0, 8'd0, 1'b0);
        send_bit("p5_b5", 1'b0, 1'b1, 8'd1, 1'b0);
        send_bit("p5_b6", 1'b0, 1'b0, 8'd1, 1'b0);
        send_bit("p5_b7", 1'b1, 1'b0, 8'd1, 1'b0);
        send_bit("p5_b8", 1'b0, OV,   OV ? 8'd2 : 8'd1, 1'b0);
        tick();
        check("p5_hit_drop", hit, 1'b0);
        pulse_abort();
        check("p5_abort_ready", cfg_ready, 1'b1);
        check("p5_abort_cnt_held", match_cnt, OV ? 8'd2 : 8'd1);

        // gaps in data_valid inside the pattern
        pulse_start();
        check("gap_cnt_clr", match_cnt, 8'd0);
        send_bit("gap_b1", 1'b1, 1'b0, 8'd0, 1'b0);
        send_bit("gap_b2", 1'b0, 1'b0, 8'd0, 1'b0);
        data = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_idle_hit", hit, 1'b0);
        end
        send_bit("gap_b3", 1'b0, 1'b0, 8'd0, 1'b0);
        send_bit("gap_b4", 1'b1, 1'b0, 8'd0, 1'b0);
        send_bit("gap_b5", 1'b0, 1'b1, 8'd1, 1'b0);

        // abort and start together in RUN
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abst_busy", busy, 1'b0);
        check("abst_ready", cfg_ready, 1'b1);
        check("abst_cnt", match_cnt, 8'd1);

        // target 2 with pattern 11
        do_cfg(8'b0000_0011, 4'd2, 8'd2);
        pulse_start();
        send_bit("t2_b1", 1'b1, 1'b0, 8'd0, 1'b0);
        send_bit("t2_b2", 1'b1, 1'b1, 8'd1, 1'b0);
        send_bit("t2_b3", 1'b1, OV,   OV ? 8'd2 : 8'd1, OV);
        send_bit("t2_b4", 1'b1, !OV,  8'd2, 1'b1);
        check("t2_busy", busy, 1'b0);
        send_bit("t2_extra", 1'b1, 1'b0, 8'd2, 1'b1);
        check("t2_done_ready", cfg_ready, 1'b0);
        do_cfg(8'h00, 4'd0, 8'd0);
        check("t2_done_no_cfg_err", cfg_err, 1'b0);
        pulse_start();
        check("t2_restart_busy", busy, 1'b1);
        check("t2_restart_cnt", match_cnt, 8'd0);
        check("t2_restart_done", done, 1'b0);
        pulse_abort();

        // full-length pattern, target 1
        do_cfg(8'hA5, 4'd8, 8'd1);
        pulse_start();
        bits8 = 8'hA5;
        for (int i = 7; i > 0; i--) send_bit("l8_pre", bits8[i], 1'b0, 8'd0, 1'b0);
        send_bit("l8_last", bits8[0], 1'b1, 8'd1, 1'b1);
        pulse_abort();

        // length 9 is rejected and stored config survives
        do_cfg(8'hFF, 4'd9, 8'd0);
        check("len9_err", cfg_err, 1'b1);
        pulse_start();
        for (int i = 7; i > 0; i--) send_bit("keep_pre", bits8[i], 1'b0, 8'd0, 1'b0);
        send_bit("keep_last", bits8[0], 1'b1, 8'd1, 1'b1);
        pulse_abort();

        // counter saturation with unlimited target
        do_cfg(8'h01, 4'd1, 8'd0);
        pulse_start();
        send_bit("sat_first", 1'b1, 1'b1, 8'd1, 1'b0);
        data = 1'b1;
        data_valid = 1'b1;
        repeat (259) tick();
        data_valid = 1'b0;
        check("sat_cnt", match_cnt, 8'hFF);
        check("sat_busy", busy, 1'b1);
        send_bit("sat_more", 1'b1, 1'b1, 8'hFF, 1'b0);

        // asynchronous reset between edges
        #3;
        rst = 1'b0;
        #1;
        check("arst_hit", hit, 1'b0);
        check("arst_cnt", match_cnt, 8'd0);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", cfg_ready, 1'b1);
        #7;
        rst = 1'b1;
        tick();
        pulse_start();
        check("arst_start_ignored", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
